// File: rtl/prim_pkg.sv
// Shared constants and types for the stream primitive cells (demux width, select width, mask type).
package prim_pkg;
  localparam int DEMUX_PORTS = 8;
  localparam int DEMUX_SEL_W = 3;

  typedef logic [DEMUX_PORTS-1:0] demux_mask_t;
endpackage

// File: rtl/prim_dec_3x8.sv
// Combinational 3-to-8 one-hot decoder; exactly one output bit is set for every select value.
module prim_dec_3x8
  import prim_pkg::*;
(
  input  logic [DEMUX_SEL_W-1:0] sel,
  output logic [DEMUX_PORTS-1:0] onehot
);

  assign onehot = demux_mask_t'(1) << sel;

endmodule

// File: rtl/prim_stream_demux_1x8.sv
// Registered 1-to-8 stream demultiplexer with a single holding stage and a pending-destination mask.
// Optional broadcast (all 8 destinations) is enabled by defining PRIM_DEMUX_BCAST_EN.
module prim_stream_demux_1x8
  import prim_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_valid,
  input  logic [DEMUX_SEL_W-1:0] i_sel,
  input  logic [WIDTH-1:0]       i_data,
`ifdef PRIM_DEMUX_BCAST_EN
  input  logic                   i_bcast,
`endif
  output logic                   o_ready,
  output logic [DEMUX_PORTS-1:0] o_valid,
  output logic [WIDTH-1:0]       o_data,
  input  logic [DEMUX_PORTS-1:0] i_ready,
  output logic                   o_busy
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  demux_mask_t      r_mask;

  demux_mask_t sel_mask;
  demux_mask_t load_mask;
  demux_mask_t remain_mask;
  logic        acc;

  prim_dec_3x8 u_dec (
    .sel    (i_sel),
    .onehot (sel_mask)
  );

`ifdef PRIM_DEMUX_BCAST_EN
  assign load_mask = i_bcast ? '1 : sel_mask;
`else
  assign load_mask = sel_mask;
`endif

  // Handshake: a transfer happens on a rising edge where valid and ready are both high.
  // Upstream ready frees the stage once every pending destination takes the item this
  // cycle, so a drain and a new accept can share one edge; it never looks at i_valid.
  assign remain_mask = r_mask & ~i_ready;
  assign o_ready     = !r_valid || ((r_mask & i_ready) == r_mask);
  assign acc         = i_valid && o_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_mask  <= '0;
    end else if (acc) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_mask  <= load_mask;
    end else begin
      r_valid <= |remain_mask;
      r_mask  <= remain_mask;
    end
  end

  assign o_valid = {DEMUX_PORTS{r_valid}} & r_mask;
  assign o_data  = r_data;
  assign o_busy  = r_valid;

endmodule

// File: tb/tb_prim_stream_demux_1x8.sv
// Self-checking bench for prim_stream_demux_1x8: directed vectors plus a destination-set model.
// Broadcast vectors are included when PRIM_DEMUX_BCAST_EN is defined.
module tb_prim_stream_demux_1x8;
  localparam int WIDTH = 32;

  // clock / reset
  logic             clk;
  logic             rst_n;
  logic             i_valid;
  logic [2:0]       i_sel;
  logic [WIDTH-1:0] i_data;
  logic [7:0]       i_ready;
  logic             o_ready;
  logic [7:0]       o_valid;
  logic [WIDTH-1:0] o_data;
  logic             o_busy;
`ifdef PRIM_DEMUX_BCAST_EN
  logic             i_bcast;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  prim_stream_demux_1x8 #(.WIDTH(WIDTH)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (i_valid),
    .i_sel   (i_sel),
    .i_data  (i_data),
`ifdef PRIM_DEMUX_BCAST_EN
    .i_bcast (i_bcast),
`endif
    .o_ready (o_ready),
    .o_valid (o_valid),
    .o_data  (o_data),
    .i_ready (i_ready),
    .o_busy  (o_busy)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // model: the item held and the set of destinations still owed a copy
  logic [WIDTH-1:0] m_data;
  bit               m_owed[8];
  // scoreboard of outstanding deliveries {dest, data}
  logic [WIDTH+2:0] exp_q[$];

  always @(negedge clk) begin
    bit             e_busy;
    bit             e_ready;
    logic [7:0]     e_valid;
    bit             take_all;
    if (!rst_n) begin
      foreach (m_owed[k]) m_owed[k] = 0;
      exp_q.delete();
      chk("rst_o_valid", o_valid, 8'h00);
      chk("rst_o_busy",  o_busy, 1'b0);
    end else begin
      e_busy  = 0;
      e_ready = 1;
      e_valid = 8'h00;
      for (int k = 0; k < 8; k++) begin
        if (m_owed[k]) begin
          e_busy     = 1;
          e_valid[k] = 1'b1;
          if (!i_ready[k]) e_ready = 0;
        end
      end
      chk("mon_o_valid", o_valid, e_valid);
      chk("mon_o_busy",  o_busy, e_busy);
      chk("mon_o_ready", o_ready, e_ready);
      if (e_busy) chk("mon_o_data", o_data, m_data);

      // every actual delivery must match an outstanding entry for that destination
      for (int k = 0; k < 8; k++) begin
        if (o_valid[k] && i_ready[k]) begin
          int idx;
          idx = -1;
          for (int j = 0; j < exp_q.size(); j++)
            if (idx < 0 && exp_q[j][WIDTH+2:WIDTH] == 3'(k)) idx = j;
          if (idx < 0) chk("deliver_expected", 1'b0, 1'b1);
          else begin
            chk("deliver_data", o_data, exp_q[idx][WIDTH-1:0]);
            exp_q.delete(idx);
          end
        end
      end

      // advance the model across the coming rising edge
      take_all = 0;
`ifdef PRIM_DEMUX_BCAST_EN
      take_all = i_bcast;
`endif
      if (i_valid && e_ready) begin
        m_data = i_data;
        for (int k = 0; k < 8; k++) begin
          m_owed[k] = take_all || (int'(i_sel) == k);
          if (m_owed[k]) exp_q.push_back({3'(k), i_data});
        end
      end else begin
        for (int k = 0; k < 8; k++) if (i_ready[k]) m_owed[k] = 0;
      end
    end
  end

  // driver tasks
  task automatic drive(input logic v, input logic [2:0] sel, input logic [WIDTH-1:0] d,
                       input logic [7:0] rdy, input logic b);
    @(posedge clk);
    #1;
    i_valid = v;
    i_sel   = sel;
    i_data  = d;
    i_ready = rdy;
`ifdef PRIM_DEMUX_BCAST_EN
    i_bcast = b;
`else
    if (b) $display("note: broadcast request ignored in this build");
`endif
  endtask

  task automatic idle(input logic [7:0] rdy);
    drive(1'b0, 3'd0, '0, rdy, 1'b0);
  endtask

  initial begin
    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_sel   = 3'd0;
    i_data  = '0;
    i_ready = 8'hFF;
`ifdef PRIM_DEMUX_BCAST_EN
    i_bcast = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_o_ready", o_ready, 1'b1);
    chk("reset_o_busy",  o_busy, 1'b0);
    chk("reset_o_data",  o_data, 32'h0);

    // unicast to port 5
    drive(1'b1, 3'd5, 32'hDEADBEEF, 8'hFF, 1'b0);
    @(negedge clk);
    chk("uni_accept_ready", o_ready, 1'b1);
    idle(8'hFF);
    @(negedge clk);
    chk("uni_o_valid", o_valid, 8'h20);
    chk("uni_o_data",  o_data, 32'hDEADBEEF);
    idle(8'hFF);
    @(negedge clk);
    chk("uni_drained", o_valid, 8'h00);

    // backpressure on port 2
    drive(1'b1, 3'd2, 32'hA5A5_0002, 8'hFB, 1'b0);
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 3'd7, 32'h1111_1111, 8'hFB, 1'b0);
      @(negedge clk);
      chk("bp_o_valid", o_valid, 8'h04);
      chk("bp_o_data",  o_data, 32'hA5A5_0002);
      chk("bp_o_ready", o_ready, 1'b0);
    end
    idle(8'hFF);
    @(negedge clk);
    chk("bp_release_ready", o_ready, 1'b1);

    // streaming 0..7 back to back
    for (int i = 0; i < 8; i++) begin
      logic [7:0] e;
      drive(1'b1, 3'(i), 32'hC0DE_0000 + 32'(i), 8'hFF, 1'b0);
      @(negedge clk);
      chk("stream_ready", o_ready, 1'b1);
      if (i > 0) begin
        e = 8'h01 << (i - 1);
        chk("stream_o_valid", o_valid, e);
        chk("stream_o_data", o_data, 32'hC0DE_0000 + 32'(i - 1));
      end
    end
    idle(8'hFF);
    @(negedge clk);
    chk("stream_last", o_valid, 8'h80);
    idle(8'hFF);

    // readiness of non-pending destinations must not release port 3
    drive(1'b1, 3'd3, 32'h3333_3333, 8'hF7, 1'b0);
    for (int c = 0; c < 2; c++) begin
      idle(8'hF7);
      @(negedge clk);
      chk("ign_o_valid", o_valid, 8'h08);
      chk("ign_o_ready", o_ready, 1'b0);
    end
    idle(8'hFF);
    @(negedge clk);
    chk("ign_release", o_ready, 1'b1);

`ifdef PRIM_DEMUX_BCAST_EN
    // broadcast drained in two halves
    drive(1'b1, 3'd0, 32'hB0B0_B0B0, 8'h0F, 1'b1);
    idle(8'h0F);
    @(negedge clk);
    chk("bc_o_valid_all", o_valid, 8'hFF);
    chk("bc_ready_first", o_ready, 1'b0);
    idle(8'hF0);
    @(negedge clk);
    chk("bc_o_valid_hi", o_valid, 8'hF0);
    chk("bc_ready_second", o_ready, 1'b1);
    idle(8'hFF);
    @(negedge clk);
    chk("bc_o_valid_done", o_valid, 8'h00);
`endif

    // mixed traffic checked by the model
    for (int c = 0; c < 200; c++) begin
      drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
            8'($urandom_range(0, 255)), 1'($urandom_range(0, 5) == 0));
    end
    idle(8'hFF);
    idle(8'hFF);

    // reset while an item waits on port 6
    drive(1'b1, 3'd6, 32'h6666_0006, 8'h00, 1'b0);
    idle(8'h00);
    @(negedge clk);
    chk("rst_mid_pending", o_valid, 8'h40);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_async_valid", o_valid, 8'h00);
    chk("rst_mid_async_busy",  o_busy, 1'b0);
    i_ready = 8'hFF;
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_after_ready", o_ready, 1'b1);
    chk("rst_mid_after_busy",  o_busy, 1'b0);

    idle(8'hFF);
    idle(8'hFF);
    @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
